// File: rtl/hook_pkg.sv
// Shared types and constants for the hook kinematics controller.
package hook_pkg;

  typedef enum logic [2:0] {
    ST_SWING,
    ST_DROP,
    ST_DRAG,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  localparam logic [1:0] PL_NONE  = 2'b00;
  localparam logic [1:0] PL_GOLD  = 2'b01;
  localparam logic [1:0] PL_STONE = 2'b10;

  localparam logic [3:0] IDX_MAX   = 4'd10;
  localparam logic [3:0] IDX_RESET = 4'd5;

  // Discrete swing angles in degrees, indexed 0..IDX_MAX.
  function automatic logic [7:0] angle_of(input logic [3:0] idx);
    case (idx)
      4'd0:    angle_of = 8'd30;
      4'd1:    angle_of = 8'd40;
      4'd2:    angle_of = 8'd50;
      4'd3:    angle_of = 8'd60;
      4'd4:    angle_of = 8'd80;
      4'd5:    angle_of = 8'd90;
      4'd6:    angle_of = 8'd100;
      4'd7:    angle_of = 8'd120;
      4'd8:    angle_of = 8'd130;
      4'd9:    angle_of = 8'd140;
      4'd10:   angle_of = 8'd150;
      default: angle_of = 8'd90;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one-cycle registered tick every FRAME_DIV clocks.
module frame_tick_gen #(
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic frame
);

  localparam int unsigned CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(FRAME_DIV - 2);

  logic [CW-1:0] cnt;

  // Tick is registered one count early so it is high exactly while cnt == LAST.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt   <= '0;
      frame <= 1'b0;
    end else begin
      cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      frame <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/hook_motion_ctrl.sv
// Hook kinematics: swing through the angle table, drop, drag back, settle, hold.
module hook_motion_ctrl
  import hook_pkg::*;
#(
  parameter int unsigned FRAME_DIV  = 833333,
  parameter logic [7:0]  MAX_LEN    = 8'd150,
  parameter logic [7:0]  DROP_STEP  = 8'd2,
  parameter logic [7:0]  DRAG_EMPTY = 8'd4,
  parameter logic [7:0]  DRAG_GOLD  = 8'd2,
  parameter logic [7:0]  DRAG_STONE = 8'd1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       drop_btn,
  input  logic       hit_gold,
  input  logic       hit_stone,
  input  logic       game_end,
  input  logic       go,
  output logic       frame,
  output logic       clockwise,
  output logic [7:0] degree_to_fsm,
  output logic       drop,
  output logic       drop_end,
  output logic       drag_end,
  output logic [7:0] hook_len,
  output logic [1:0] payload
);

  state_t     state;
  logic [3:0] idx;
  logic [3:0] sw_idx;
  logic       sw_cw;
  logic       btn_q;
  logic       btn_rise;
  logic       reinit;
  logic [8:0] len_sum;
  logic [7:0] len_up;
  logic [7:0] drag_step;
  logic [7:0] len_dn;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .frame  (frame)
  );

  assign btn_rise = drop_btn & ~btn_q;
  // A go pulse only matters in HOLD, and game_end still beats it.
  assign reinit   = (state == ST_HOLD) && go && !game_end;

  // Next swing position; bounces off either end of the table on the same frame.
  always_comb begin
    sw_idx = idx;
    sw_cw  = clockwise;
    if (clockwise) begin
      if (idx == IDX_MAX) begin
        sw_idx = IDX_MAX - 4'd1;
        sw_cw  = 1'b0;
      end else begin
        sw_idx = idx + 4'd1;
      end
    end else begin
      if (idx == 4'd0) begin
        sw_idx = 4'd1;
        sw_cw  = 1'b1;
      end else begin
        sw_idx = idx - 4'd1;
      end
    end
  end

  // Length arithmetic: saturating extend, payload-dependent clamped retract.
  always_comb begin
    len_sum = {1'b0, hook_len} + {1'b0, DROP_STEP};
    len_up  = (len_sum > {1'b0, MAX_LEN}) ? MAX_LEN : len_sum[7:0];
    case (payload)
      PL_GOLD:  drag_step = DRAG_GOLD;
      PL_STONE: drag_step = DRAG_STONE;
      default:  drag_step = DRAG_EMPTY;
    endcase
    len_dn = (hook_len > drag_step) ? hook_len - drag_step : 8'd0;
  end

  // Phase FSM with registered phase flags, angle, length and payload.
  always_ff @(posedge clk) begin
    btn_q <= drop_btn;
    if (!resetn || reinit) begin
      state         <= ST_SWING;
      idx           <= IDX_RESET;
      clockwise     <= 1'b1;
      degree_to_fsm <= angle_of(IDX_RESET);
      hook_len      <= 8'd0;
      payload       <= PL_NONE;
      drop          <= 1'b0;
      drop_end      <= 1'b0;
      drag_end      <= 1'b0;
      if (!resetn) btn_q <= 1'b0;
    end else if (game_end) begin
      state    <= ST_HOLD;
      hook_len <= 8'd0;
      drop     <= 1'b0;
      drop_end <= 1'b0;
      drag_end <= 1'b0;
    end else begin
      case (state)
        ST_SWING: begin
          if (btn_rise) begin
            state <= ST_DROP;
            drop  <= 1'b1;
          end else if (frame) begin
            idx           <= sw_idx;
            clockwise     <= sw_cw;
            degree_to_fsm <= angle_of(sw_idx);
          end
        end
        ST_DROP: begin
          if (frame) begin
            if (hit_gold || hit_stone || hook_len == MAX_LEN) begin
              payload  <= hit_gold ? PL_GOLD : (hit_stone ? PL_STONE : PL_NONE);
              state    <= ST_DRAG;
              drop     <= 1'b0;
              drop_end <= 1'b1;
            end else begin
              hook_len <= len_up;
            end
          end
        end
        ST_DRAG: begin
          if (frame) begin
            hook_len <= len_dn;
            if (len_dn == 8'd0) begin
              state    <= ST_SETTLE;
              drop_end <= 1'b0;
              drag_end <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (frame) begin
            payload  <= PL_NONE;
            state    <= ST_SWING;
            drag_end <= 1'b0;
          end
        end
        ST_HOLD: ;
        default: state <= ST_SWING;
      endcase
    end
  end

endmodule

// File: tb/tb_hook_motion_ctrl.sv
// Randomised and directed bench for hook_motion_ctrl against a phase-level model.
module tb_hook_motion_ctrl;

  localparam int FD = 4;
  localparam int P_SW = 0, P_DROP = 1, P_DRAG = 2, P_SET = 3, P_HOLD = 4;
  localparam logic [22:0] RESET_VEC = {1'b0, 1'b1, 8'd90, 3'b000, 8'd0, 2'b00};

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic drop_btn = 1'b0, hit_gold = 1'b0, hit_stone = 1'b0, game_end = 1'b0, go = 1'b0;
  logic frame, clockwise, drop, drop_end, drag_end;
  logic [7:0] degree_to_fsm, hook_len;
  logic [1:0] payload;
  logic [22:0] dut_vec;

  int tests = 0;
  int fails = 0;

  // Model: swing is a position on a 20-frame bounce cycle, length is plain integer math.
  int mcnt, mp, mph, mlen, mpay;
  logic mprev;
  int ANG [11] = '{30, 40, 50, 60, 80, 90, 100, 120, 130, 140, 150};

  hook_motion_ctrl #(.FRAME_DIV(FD)) dut (
    .clk(clk), .resetn(resetn), .drop_btn(drop_btn), .hit_gold(hit_gold),
    .hit_stone(hit_stone), .game_end(game_end), .go(go), .frame(frame),
    .clockwise(clockwise), .degree_to_fsm(degree_to_fsm), .drop(drop),
    .drop_end(drop_end), .drag_end(drag_end), .hook_len(hook_len), .payload(payload)
  );

  assign dut_vec = {frame, clockwise, degree_to_fsm, drop, drop_end, drag_end, hook_len, payload};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  function automatic int idx_of(input int p);
    return (p <= 10) ? p : 20 - p;
  endfunction

  function automatic bit cw_of(input int p);
    return (p >= 1 && p <= 10);
  endfunction

  function automatic logic [22:0] exp_vec();
    return {(mcnt == FD - 1), cw_of(mp), 8'(ANG[idx_of(mp)]), (mph == P_DROP),
            (mph == P_DRAG), (mph == P_SET), 8'(mlen), 2'(mpay)};
  endfunction

  always @(posedge clk) begin
    bit fr, rise;
    int step;
    if (!resetn) begin
      mcnt = 0; mp = 5; mph = P_SW; mlen = 0; mpay = 0; mprev = 1'b0;
    end else begin
      fr    = (mcnt == FD - 1);
      rise  = drop_btn && !mprev;
      mprev = drop_btn;
      if (game_end) begin
        mph = P_HOLD; mlen = 0;
      end else if (mph == P_HOLD) begin
        if (go) begin mp = 5; mph = P_SW; mlen = 0; mpay = 0; end
      end else if (mph == P_SW) begin
        if (rise) mph = P_DROP;
        else if (fr) mp = (mp + 1) % 20;
      end else if (fr) begin
        if (mph == P_DROP) begin
          if (hit_gold) begin mpay = 1; mph = P_DRAG; end
          else if (hit_stone) begin mpay = 2; mph = P_DRAG; end
          else if (mlen == 150) begin mpay = 0; mph = P_DRAG; end
          else mlen = (mlen + 2 > 150) ? 150 : mlen + 2;
        end else if (mph == P_DRAG) begin
          step = (mpay == 1) ? 2 : (mpay == 2) ? 1 : 4;
          mlen = (mlen - step < 0) ? 0 : mlen - step;
          if (mlen == 0) mph = P_SET;
        end else begin
          mpay = 0; mph = P_SW;
        end
      end
      mcnt = (mcnt + 1) % FD;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drop_btn = 0; hit_gold = 0; hit_stone = 0; game_end = 0; go = 0; resetn = 0;
    tick(); tick();
    resetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (dut_vec !== RESET_VEC) begin
      fails++; $display("FAIL reset_values: got %h want %h", dut_vec, RESET_VEC);
    end
  endtask

  task automatic test_swing();
    logic [7:0] prev;
    bit seen150 = 0, seen30 = 0;
    do_reset();
    prev = degree_to_fsm;
    repeat (60 * FD) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL swing_trace: got %h want %h", dut_vec, exp_vec());
      end
      if (prev == 8'd150 && degree_to_fsm != 8'd150) begin
        seen150 = 1; tests++;
        if (clockwise !== 1'b0) begin fails++; $display("FAIL swing_cw_fall: got %b want 0", clockwise); end
      end
      if (prev == 8'd30 && degree_to_fsm != 8'd30) begin
        seen30 = 1; tests++;
        if (clockwise !== 1'b1) begin fails++; $display("FAIL swing_cw_rise: got %b want 1", clockwise); end
      end
      prev = degree_to_fsm;
    end
    tests++;
    if (!(seen150 && seen30)) begin
      fails++; $display("FAIL swing_ends: left150 %0d left30 %0d want 1 1", seen150, seen30);
    end
  endtask

  // Drop from 60 deg; raise the given hits when the modelled length equals hit_len.
  task automatic run_drop(input string nm, input int hit_len, input bit g, input bit s,
                          input int exp_drop, input int exp_drag, input logic [1:0] exp_pay);
    int guard = 0, n_drop = 0, n_drag = 0, n_set = 0;
    bit saw_set = 0;
    do_reset();
    while (!(ANG[idx_of(mp)] == 60 && mph == P_SW) && guard < 400) begin tick(); guard++; end
    tests++;
    if (guard >= 400) begin fails++; $display("FAIL %s_seek: 60 deg not reached, got %0d", nm, degree_to_fsm); return; end
    drop_btn = 1;
    guard = 0;
    while (!(saw_set && mph == P_SW) && guard < 3000) begin
      tick(); guard++;
      drop_btn = 0;
      tests++;
      if (dut_vec !== exp_vec()) begin
        fails++; $display("FAIL %s_trace: got %h want %h", nm, dut_vec, exp_vec());
      end
      if (frame && drop && hook_len < 8'd150) n_drop++;
      if (frame && drop_end) begin
        n_drag++; tests++;
        if (payload !== exp_pay) begin fails++; $display("FAIL %s_payload: got %b want %b", nm, payload, exp_pay); end
      end
      if (frame && drag_end) n_set++;
      if (mph == P_SET) saw_set = 1;
      hit_gold  = g && (mph == P_DROP) && (mlen == hit_len);
      hit_stone = s && (mph == P_DROP) && (mlen == hit_len);
    end
    hit_gold = 0; hit_stone = 0;
    tests++;
    if (guard >= 3000) begin fails++; $display("FAIL %s_timeout: no return to swing, drop %0d", nm, drop); end
    tests++;
    if (n_drop != exp_drop || n_drag != exp_drag || n_set != 1) begin
      fails++; $display("FAIL %s_frames: got drop %0d drag %0d settle %0d want %0d %0d 1",
                        nm, n_drop, n_drag, n_set, exp_drop, exp_drag);
    end
    tests++;
    if (degree_to_fsm !== 8'd60 || payload !== 2'b00) begin
      fails++; $display("FAIL %s_resume: got deg %0d pay %b want 60 00", nm, degree_to_fsm, payload);
    end
  endtask

  task automatic test_drop_no_hit();
    run_drop("nohit", -1, 0, 0, 75, 38, 2'b00);
  endtask

  task automatic test_hit_stone();
    run_drop("stone", 40, 0, 1, 21, 40, 2'b10);
  endtask

  task automatic test_gold_stone();
    int l;
    l = 2 * int'($urandom_range(5, 60));
    run_drop("goldstone", l, 1, 1, l / 2 + 1, l / 2, 2'b01);
  endtask

  task automatic test_game_end();
    int guard = 0;
    do_reset();
    drop_btn = 1;
    while (!(mph == P_DRAG && mlen <= 140) && guard < 2000) begin
      tick(); guard++; drop_btn = 0;
      tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL gameend_pre: got %h want %h", dut_vec, exp_vec()); end
    end
    tests++;
    if (guard >= 2000) begin fails++; $display("FAIL gameend_seek: drag not reached, drop_end %b", drop_end); end
    game_end = 1; tick(); game_end = 0;
    tests++;
    if ({drop, drop_end, drag_end, hook_len} !== 11'd0) begin
      fails++; $display("FAIL gameend_hold: got phases %b%b%b len %0d want 000 0", drop, drop_end, drag_end, hook_len);
    end
    repeat (10) begin
      tick(); tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL gameend_idle: got %h want %h", dut_vec, exp_vec()); end
    end
    go = 1; tick(); go = 0;
    tests++;
    if ({degree_to_fsm, clockwise, drop, drop_end, drag_end, hook_len, payload} !== {8'd90, 1'b1, 3'b000, 8'd0, 2'b00}) begin
      fails++; $display("FAIL gameend_go: got deg %0d cw %b len %0d want 90 1 0", degree_to_fsm, clockwise, hook_len);
    end
    drop_btn = 1;
    repeat (12) begin
      tick(); drop_btn = 0; tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL midreset_pre: got %h want %h", dut_vec, exp_vec()); end
    end
    resetn = 0; tick(); resetn = 1;
    tests++;
    if (dut_vec !== RESET_VEC) begin fails++; $display("FAIL midreset: got %h want %h", dut_vec, RESET_VEC); end
  endtask

  task automatic test_btn_on_frame();
    int guard = 0;
    int d0;
    do_reset();
    tick();
    while (mcnt != FD - 1 && guard < 20) begin tick(); guard++; end
    tests++;
    if (frame !== 1'b1) begin fails++; $display("FAIL btnframe_align: frame got %b want 1", frame); end
    d0 = ANG[idx_of(mp)];
    drop_btn = 1; tick(); drop_btn = 0;
    tests++;
    if (degree_to_fsm !== 8'(d0) || drop !== 1'b1) begin
      fails++; $display("FAIL btnframe: got deg %0d drop %b want %0d 1", degree_to_fsm, drop, d0);
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (5000) begin
      tick(); tests++;
      if (dut_vec !== exp_vec()) begin fails++; $display("FAIL random_trace: got %h want %h", dut_vec, exp_vec()); end
      drop_btn  = ($urandom % 8) == 0;
      hit_gold  = ($urandom % 16) == 0;
      hit_stone = ($urandom % 12) == 0;
      game_end  = ($urandom % 600) == 0;
      go        = ($urandom % 40) == 0;
      resetn    = ($urandom % 1500) != 0;
    end
    resetn = 1;
  endtask

  initial begin
    test_reset();
    test_swing();
    test_drop_no_hit();
    test_hit_stone();
    test_gold_stone();
    test_game_end();
    test_btn_on_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hook_motion_ctrl.md
# hook_motion_ctrl

Hook kinematics controller for the gold-miner game: generates the frame tick, swings the hook through the discrete angle set, extends and retracts the hook line, and reports drop/drag completion. Sits directly upstream of the game view FSM and drives its `frame`, `clockwise`, `degree_to_fsm`, `drop`, `drop_end` and `drag_end` inputs. Also exports hook length and payload for the renderer and scorer.

## Interface
Parameters:
- `FRAME_DIV`, 833333: clk cycles per frame (60 Hz at 50 MHz); must be ≥ 2.
- `MAX_LEN`, 8'd150: maximum hook length, in pixels.
- `DROP_STEP`, 8'd2: length gained per frame while dropping.
- `DRAG_EMPTY`, 8'd4: length lost per frame when the payload is empty.
- `DRAG_GOLD`, 8'd2: length lost per frame when carrying gold.
- `DRAG_STONE`, 8'd1: length lost per frame when carrying stone.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, synchronous, active-low; clock is `clk`.
- `drop_btn`  in  1  player button, level, already synchronised.
- `hit_gold`  in  1  collision detector: hook tip overlaps gold (level).
- `hit_stone`  in  1  collision detector: hook tip overlaps stone (level).
- `game_end`  in  1  timer expired (level).
- `go`  in  1  restart request.
- `frame`  out  1  one-cycle tick per frame.
- `clockwise`  out  1  1 = angle index increasing.
- `degree_to_fsm`  out  8  current angle in degrees.
- `drop`  out  1  high throughout the DROP phase.
- `drop_end`  out  1  high throughout the DRAG phase.
- `drag_end`  out  1  high throughout the SETTLE phase.
- `hook_len`  out  8  current hook length.
- `payload`  out  2  00 none, 01 gold, 10 stone.

## Operation
- Angle table, index 0..10: 30, 40, 50, 60, 80, 90, 100, 120, 130, 140, 150.
- `degree_to_fsm` = table[idx].
- States:
  - SWING: on each `frame`, move idx ±1 in the direction of `clockwise`.
    - At idx 10 with `clockwise` = 1: set `clockwise` = 0 and idx = 9 on the same frame.
    - At idx 0 with `clockwise` = 0: set `clockwise` = 1 and idx = 1.
    - A rising edge of `drop_btn` (registered previous value) moves to DROP.
  - DROP: on each `frame`, check for a hit first.
    - If `hit_gold` → payload = 01, go to DRAG. If `hit_stone` only → payload = 10, go to DRAG. Gold has priority when both are high.
    - Otherwise `hook_len` += DROP_STEP, saturating at MAX_LEN.
    - If `hook_len` is already at MAX_LEN, go to DRAG with payload = 00.
  - DRAG: on each `frame`, `hook_len` -= step selected by payload, clamped at 0. The frame on which 0 is reached goes to SETTLE.
  - SETTLE: lasts exactly one frame; on the next `frame`, clear payload and go to SWING.
  - HOLD: entered from any state when `game_end` = 1. `hook_len` is forced to 0; all phase outputs are low. A `go` pulse reinitialises to reset values and enters SWING.
- Angle and `clockwise` are frozen outside SWING.
- Drop-button edges outside SWING are ignored; they are not queued.

## Timing
- Reset values:
  - state SWING, idx 5 (90°), `clockwise` 1.
  - `hook_len` 0, `payload` 00, frame counter 0.
  - `frame`, `drop`, `drop_end`, `drag_end` all 0.
- `frame` is 1 when the counter equals FRAME_DIV−1; the counter then wraps to 0. It free-runs in every state, including HOLD.
- All outputs are registered. A state change is visible on the outputs one cycle after the deciding edge.
- A `drop_btn` edge moves to DROP on the next clock, independent of `frame`.
  - If the edge coincides with `frame`, DROP wins and the angle does not advance.
- `game_end` overrides every other event in the same cycle.
- `go` while not in HOLD is ignored.
- Reset mid-phase returns immediately to the reset values.

## Structure
- Shared `hook_pkg` holds:
  - state encoding (SWING, DROP, DRAG, SETTLE, HOLD);
  - payload encodings;
  - the 11-entry angle table as a constant function;
  - IDX_MAX = 10 and IDX_RESET = 5.
- Sub-module `frame_tick_gen` (parameter FRAME_DIV; ports `clk`, `resetn`, `frame`) is natural.
- The remainder is one FSM plus the idx, length and payload registers.

## Test plan
- FRAME_DIV = 4, reset, idle for 60 frames → `degree_to_fsm` goes 90, 100, 120, 130, 140, 150, 140, …, 30, 40. `clockwise` falls on the frame leaving 150 and rises on the frame leaving 30.
- Press `drop_btn` at 60°, no hits → `drop` high for 75 frames while `hook_len` climbs 2/frame to 150. Then `drop_end` is high for 38 frames and `hook_len` falls 4/frame to 0. Then `drag_end` is high for 1 frame, then SWING resumes at 60°.
- Assert `hit_stone` when `hook_len` = 40 → `payload` = 10, DRAG at 1/frame, 40 frames until SETTLE; `payload` returns to 00 on entering SWING.
- `hit_gold` and `hit_stone` together → `payload` = 01, drag step 2.
- `game_end` mid-DRAG → next cycle all phase outputs are 0 and `hook_len` = 0; `go` → 90°, `clockwise` = 1.
- `drop_btn` edge on the same cycle as `frame` → `degree_to_fsm` unchanged and `drop` = 1.
